// File: rtl/rat_rename.sv
// Four-wide register alias table with in-group bypass,
// per-lane snapshots and whole-table restore.
module rat_rename (
  input  logic         clk,
  input  logic         reset,
  input  logic         ren_valid,
  output logic         ren_ready,
  input  logic [4:0]   src1_a,
  input  logic [4:0]   src1_b,
  input  logic [4:0]   src1_c,
  input  logic [4:0]   src1_d,
  input  logic [4:0]   src2_a,
  input  logic [4:0]   src2_b,
  input  logic [4:0]   src2_c,
  input  logic [4:0]   src2_d,
  input  logic [4:0]   dst_a,
  input  logic [4:0]   dst_b,
  input  logic [4:0]   dst_c,
  input  logic [4:0]   dst_d,
  input  logic         dst_we_a,
  input  logic         dst_we_b,
  input  logic         dst_we_c,
  input  logic         dst_we_d,
  input  logic [7:0]   new_tag_a,
  input  logic [7:0]   new_tag_b,
  input  logic [7:0]   new_tag_c,
  input  logic [7:0]   new_tag_d,
  input  logic         br_a,
  input  logic         br_b,
  input  logic         br_c,
  input  logic         br_d,
  output logic [7:0]   psrc1_a,
  output logic [7:0]   psrc1_b,
  output logic [7:0]   psrc1_c,
  output logic [7:0]   psrc1_d,
  output logic [7:0]   psrc2_a,
  output logic [7:0]   psrc2_b,
  output logic [7:0]   psrc2_c,
  output logic [7:0]   psrc2_d,
  output logic [7:0]   pold_a,
  output logic [7:0]   pold_b,
  output logic [7:0]   pold_c,
  output logic [7:0]   pold_d,
  output logic         out_valid,
  output logic [255:0] rat_shot_out_a,
  output logic [255:0] rat_shot_out_b,
  output logic [255:0] rat_shot_out_c,
  output logic [255:0] rat_shot_out_d,
  output logic         rat_start_a,
  output logic         rat_start_b,
  output logic         rat_start_c,
  output logic         rat_start_d,
  input  logic [3:0]   shot_air_cnt,
  input  logic [255:0] rob_kill_adderss,
  input  logic         rob_kill_start
);

  logic [3:0][4:0] s1, s2, d;
  logic [3:0][7:0] tag;
  logic [3:0]      we, br;

  assign s1  = {src1_d, src1_c, src1_b, src1_a};
  assign s2  = {src2_d, src2_c, src2_b, src2_a};
  assign d   = {dst_d, dst_c, dst_b, dst_a};
  assign tag = {new_tag_d, new_tag_c, new_tag_b, new_tag_a};
  assign we  = {dst_we_d, dst_we_c, dst_we_b, dst_we_a};
  assign br  = {br_d, br_c, br_b, br_a};

  logic [255:0]    rat;
  logic [4:0][255:0] img;
  logic [3:0][7:0] p1_n, p2_n, po_n;
  logic [2:0]      nb;
  logic            accept;

  assign nb = {2'b0, br[0]} + {2'b0, br[1]}
            + {2'b0, br[2]} + {2'b0, br[3]};

  assign ren_ready = !reset && !rob_kill_start
                  && ({1'b0, nb} <= shot_air_cnt);
  assign accept = ren_valid && ren_ready;

  // img[k] is the table as seen by lane k; img[k+1] is its snapshot
  always_comb begin
    img[0] = rat;
    p1_n = '0;
    p2_n = '0;
    po_n = '0;
    for (int k = 0; k < 4; k++) begin
      img[k+1] = img[k];
      if (s1[k] != 5'd0)
        p1_n[k] = img[k][{s1[k], 3'b000} +: 8];
      if (s2[k] != 5'd0)
        p2_n[k] = img[k][{s2[k], 3'b000} +: 8];
      if (d[k] != 5'd0)
        po_n[k] = img[k][{d[k], 3'b000} +: 8];
      if (we[k] && d[k] != 5'd0)
        img[k+1][{d[k], 3'b000} +: 8] = tag[k];
    end
  end

  logic [3:0][7:0]   p1_q, p2_q, po_q;
  logic [3:0][255:0] shot_q;
  logic [3:0]        start_q;
  logic              ov_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        rat[i*8 +: 8] <= 8'(i);
      p1_q    <= '0;
      p2_q    <= '0;
      po_q    <= '0;
      shot_q  <= '0;
      start_q <= '0;
      ov_q    <= 1'b0;
    end else if (rob_kill_start) begin
      rat     <= rob_kill_adderss & ~256'hff;
      start_q <= '0;
      ov_q    <= 1'b0;
    end else if (accept) begin
      rat     <= img[4];
      p1_q    <= p1_n;
      p2_q    <= p2_n;
      po_q    <= po_n;
      shot_q  <= {img[4], img[3], img[2], img[1]};
      start_q <= br;
      ov_q    <= 1'b1;
    end else begin
      start_q <= '0;
      ov_q    <= 1'b0;
    end
  end

  assign {psrc1_d, psrc1_c, psrc1_b, psrc1_a} = p1_q;
  assign {psrc2_d, psrc2_c, psrc2_b, psrc2_a} = p2_q;
  assign {pold_d, pold_c, pold_b, pold_a}     = po_q;
  assign {rat_start_d, rat_start_c,
          rat_start_b, rat_start_a}           = start_q;
  assign rat_shot_out_a = shot_q[0];
  assign rat_shot_out_b = shot_q[1];
  assign rat_shot_out_c = shot_q[2];
  assign rat_shot_out_d = shot_q[3];
  assign out_valid      = ov_q;

endmodule

// File: doc/rat_rename.md
RAT_RENAME -- requirements
Module: rat_rename

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset (polarity and synchronicity fixed): clk input 1, rising-edge clock; reset input 1, synchronous active-high.
REQ-002 SHALL have these rename inputs: ren_valid input 1, rename group present; ren_ready output 1, group accepted this cycle (combinational).
REQ-003 SHALL have, per lane x in {a,b,c,d}: src1_x, src2_x inputs 5, architectural sources; dst_x input 5, architectural destination; dst_we_x input 1, lane writes dst; new_tag_x input 8, physical tag from the free list; br_x input 1, lane needs a snapshot.
REQ-004 SHALL have, per lane x: psrc1_x, psrc2_x outputs 8, renamed sources; pold_x output 8, previous mapping of dst_x; out_valid output 1, renamed group valid (shared by all lanes).
REQ-005 SHALL have, per lane x, a snapshot port to the snapshot store: rat_shot_out_x output 256, table image with entry i at bits [8i+7:8i]; rat_start_x output 1, snapshot write strobe.
REQ-006 SHALL have shot_air_cnt input 4: free snapshot slots (0..8).
REQ-007 SHALL have recovery inputs: rob_kill_adderss input 256, image to restore; rob_kill_start input 1, restore strobe.

Function
REQ-008 SHALL hold a 32-entry x 8-bit mapping table, arch reg i -> physical tag.
REQ-009 SHALL treat arch reg 0 as hardwired: source reads return 8'd0; a write to dst 0 is ignored (no table update, pold 0, no bypass).
REQ-010 SHALL count nb = number of lanes with br_x=1, and drive ren_ready = !rob_kill_start && (nb <= shot_air_cnt).
REQ-011 SHALL accept a group when ren_valid && ren_ready at a rising edge; an unaccepted group SHALL cause no table change and no output strobes.
REQ-012 SHALL rename lanes in order a,b,c,d: a lane's sources and pold see the table plus the writes of all earlier lanes in the group whose dst_we=1 and dst!=0.
REQ-013 SHALL bypass from the youngest matching earlier lane when several earlier lanes write the same arch reg.
REQ-014 SHALL resolve same-dst writes within one group last-lane-wins at the table update.
REQ-015 SHALL form lane x's snapshot as the table image after applying lanes a..x inclusive.
REQ-016 SHALL register all outputs: results of a group accepted at edge N are valid from edge N until edge N+1 (1-cycle latency), with out_valid=1 and rat_start_x=br_x for the group.
REQ-017 SHALL drive out_valid=0 and all rat_start_x=0 in cycles with no accepted group; data outputs SHALL then hold their last values.
REQ-018 SHALL load the table from rob_kill_adderss at the edge where rob_kill_start=1, with entry 0 forced to 8'd0.
REQ-019 SHALL give restore priority over rename: a group presented in the restore cycle SHALL be refused (ren_ready=0), and out_valid/rat_start SHALL be 0 after that edge.
REQ-020 SHALL let a group accepted on the edge after a restore read the restored table.
REQ-021 SHALL not gate lanes individually: a group is accepted or refused as a whole; lanes with dst_we=0 and br=0 still produce psrc outputs.

Reset
REQ-022 SHALL, while reset=1 at a rising edge, set table entry i = i (identity map, 0..31).
REQ-023 SHALL, at reset, drive out_valid=0, all rat_start_x=0, and all psrc/pold/rat_shot_out registers to 0.
REQ-024 SHALL give reset priority over restore and rename; ren_ready SHALL be 0 while reset=1.

Verification
REQ-025 SHALL cover reset then a single lane a: src1=5, dst=3, new_tag=40 -> next cycle psrc1_a=5, pold_a=3, out_valid=1; then src1_a=3 -> 40.
REQ-026 SHALL cover an intra-group chain: a writes r7<-50, b writes r7<-51, c reads r7, d reads r7 and writes r7<-52 -> psrc c=51, pold_d=51, psrc d=51; table r7 afterwards = 52.
REQ-027 SHALL cover snapshots: br_b=1, a writes r2<-60, b writes r4<-61, c writes r2<-62 -> rat_start_b only; rat_shot_out_b has entries 2=60 and 4=61, not 62.
REQ-028 SHALL cover snapshot backpressure: br_a=br_c=1 with shot_air_cnt=1 -> ren_ready=0 and table unchanged; with shot_air_cnt=2 -> accepted.
REQ-029 SHALL cover restore collision: rob_kill_start=1 with an image mapping r9=77 while ren_valid=1 -> group refused, out_valid=0; next group reads r9 -> 77.
REQ-030 SHALL cover arch reg 0: dst_a=0, new_tag=90, then src1=0 -> psrc=0, pold_a=0; a restore image with entry 0=33 -> entry 0 still reads 0.
